// File: rtl/step_sweep_ctrl_if.sv
// rtl/step_sweep_ctrl_if.sv - control, config and step bundle between config regs, sweep scheduler and wave generator
//
// Signals:
//   enable_pulse      clock-divider tick (dwell time base)
//   start / abort     one-cycle sweep requests
//   cfg_start_step, cfg_stop_step, cfg_delta, cfg_dwell, cfg_loop, cfg_tri
//                     sweep program, sampled by the scheduler on start
//   step_out          step value for the wave generator
//   busy, done, wrap  sweep status
// Modports:
//   master  drives requests and config, observes status (config side / bench)
//   slave   the sweep scheduler
interface step_sweep_ctrl_if #(
  parameter int STEP_WIDTH  = 12,
  parameter int DWELL_WIDTH = 16
);
  logic                   enable_pulse;
  logic                   start;
  logic                   abort;
  logic [STEP_WIDTH-1:0]  cfg_start_step;
  logic [STEP_WIDTH-1:0]  cfg_stop_step;
  logic [STEP_WIDTH-1:0]  cfg_delta;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   cfg_loop;
  logic                   cfg_tri;
  logic [STEP_WIDTH-1:0]  step_out;
  logic                   busy;
  logic                   done;
  logic                   wrap;

  modport master (
    output enable_pulse, start, abort,
    output cfg_start_step, cfg_stop_step, cfg_delta, cfg_dwell, cfg_loop, cfg_tri,
    input  step_out, busy, done, wrap
  );

  modport slave (
    input  enable_pulse, start, abort,
    input  cfg_start_step, cfg_stop_step, cfg_delta, cfg_dwell, cfg_loop, cfg_tri,
    output step_out, busy, done, wrap
  );
endinterface

// File: rtl/step_sweep_ctrl.sv
// rtl/step_sweep_ctrl.sv - frequency-sweep scheduler driving the wave generator step value
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    step_sweep_ctrl_if.slave: enable_pulse/start/abort requests, cfg_* sweep
//          program, step_out/busy/done/wrap results (all outputs registered)
// Options:
//   SWEEP_TRIANGLE_EN  when defined, cfg_tri=1 makes the sweep ramp back from stop to
//                      start before ending; when undefined cfg_tri is ignored.
module step_sweep_ctrl #(
  parameter int STEP_WIDTH  = 12,
  parameter int DWELL_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  step_sweep_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                 state, state_n;
  logic [STEP_WIDTH-1:0]  step_q, step_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;
  logic                   wrap_q, wrap_n;
  logic [DWELL_WIDTH-1:0] dwell_cnt, cnt_n;
  logic                   load;

  // Sweep program captured on start; config writes mid-sweep do not disturb it.
  logic [STEP_WIDTH-1:0]  sh_start;
  logic [STEP_WIDTH-1:0]  sh_stop;
  logic [STEP_WIDTH-1:0]  sh_delta;
  logic [DWELL_WIDTH-1:0] sh_dwell;
  logic                   sh_loop;
  logic                   dir_down;

  // Current leg endpoint and direction, and the first value of a looped restart.
  logic [STEP_WIDTH-1:0]  leg_target;
  logic                   leg_down;
  logic [STEP_WIDTH-1:0]  restart_step;

`ifdef SWEEP_TRIANGLE_EN
  logic                   sh_tri;
  logic                   ret_q, ret_n;   // 1 while ramping from stop back to start
`else
  logic                   unused_tri;
  assign unused_tri = bus.cfg_tri;
`endif

  // Move one delta toward target, computed one bit wider so the result can neither
  // overshoot the target nor wrap through zero or the maximum code.
  function automatic logic [STEP_WIDTH-1:0] move_toward(
    input logic [STEP_WIDTH-1:0] cur,
    input logic [STEP_WIDTH-1:0] target,
    input logic [STEP_WIDTH-1:0] delta,
    input logic                  down
  );
    logic [STEP_WIDTH:0] sum;
    logic [STEP_WIDTH:0] diff;
    sum  = {1'b0, cur} + {1'b0, delta};
    diff = {1'b0, cur} - {1'b0, delta};
    if (down) begin
      if (diff[STEP_WIDTH] || (diff[STEP_WIDTH-1:0] <= target)) return target;
      return diff[STEP_WIDTH-1:0];
    end
    if (sum >= {1'b0, target}) return target;
    return sum[STEP_WIDTH-1:0];
  endfunction

  always_comb begin
    leg_target   = sh_stop;
    leg_down     = dir_down;
    restart_step = sh_start;
`ifdef SWEEP_TRIANGLE_EN
    if (ret_q) begin
      leg_target = sh_start;
      leg_down   = ~dir_down;
    end
    // A looped triangle already spent a dwell on start at the end of the return leg,
    // so the restart goes straight to the next value toward stop.
    if (sh_tri && (sh_start != sh_stop))
      restart_step = move_toward(sh_start, sh_stop, sh_delta, dir_down);
`endif
  end

  always_comb begin
    state_n = state;
    step_n  = step_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    cnt_n   = dwell_cnt;
    load    = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
    ret_n   = ret_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          load    = 1'b1;
          step_n  = bus.cfg_start_step;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = DWELL;
`ifdef SWEEP_TRIANGLE_EN
          ret_n   = 1'b0;
`endif
        end else begin
          cnt_n = '0;
        end
      end
      DWELL: begin
        if (bus.abort) begin
          // Abort wins over any advance due this cycle; step_out freezes.
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
`ifdef SWEEP_TRIANGLE_EN
          ret_n   = 1'b0;
`endif
        end else if (bus.enable_pulse) begin
          if (dwell_cnt == sh_dwell - DWELL_WIDTH'(1)) begin
            cnt_n = '0;
            if (step_q == leg_target) begin
`ifdef SWEEP_TRIANGLE_EN
              if (sh_tri && !ret_q && (sh_start != sh_stop)) begin
                ret_n  = 1'b1;
                step_n = move_toward(step_q, sh_start, sh_delta, ~dir_down);
              end else if (sh_loop) begin
                wrap_n = 1'b1;
                step_n = restart_step;
                ret_n  = 1'b0;
              end else begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
                ret_n   = 1'b0;
              end
`else
              if (sh_loop) begin
                wrap_n = 1'b1;
                step_n = restart_step;
              end else begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
              end
`endif
            end else begin
              step_n = move_toward(step_q, leg_target, sh_delta, leg_down);
            end
          end else begin
            cnt_n = dwell_cnt + DWELL_WIDTH'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      dwell_cnt <= '0;
`ifdef SWEEP_TRIANGLE_EN
      ret_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      step_q    <= step_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      wrap_q    <= wrap_n;
      dwell_cnt <= cnt_n;
`ifdef SWEEP_TRIANGLE_EN
      ret_q     <= ret_n;
`endif
    end
  end

  // Zero delta or dwell would stall the sweep, so both are floored at 1 on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_start <= '0;
      sh_stop  <= '0;
      sh_delta <= '0;
      sh_dwell <= '0;
      sh_loop  <= 1'b0;
      dir_down <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      sh_tri   <= 1'b0;
`endif
    end else if (load) begin
      sh_start <= bus.cfg_start_step;
      sh_stop  <= bus.cfg_stop_step;
      sh_delta <= (bus.cfg_delta == '0) ? STEP_WIDTH'(1) : bus.cfg_delta;
      sh_dwell <= (bus.cfg_dwell == '0) ? DWELL_WIDTH'(1) : bus.cfg_dwell;
      sh_loop  <= bus.cfg_loop;
      dir_down <= (bus.cfg_stop_step < bus.cfg_start_step);
`ifdef SWEEP_TRIANGLE_EN
      sh_tri   <= bus.cfg_tri;
`endif
    end
  end

  assign bus.step_out = step_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_step_sweep_ctrl.sv
// tb/tb_step_sweep_ctrl.sv - directed self-checking bench for step_sweep_ctrl
module tb_step_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  step_sweep_ctrl_if bus ();

  step_sweep_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int wrap_seen = 0;

  // One clock with the given enable_pulse level; outputs are read 1 ns after the edge.
  task automatic tick(input logic en);
    bus.enable_pulse = en;
    @(posedge clk);
    #1;
    bus.enable_pulse = 1'b0;
    if (bus.done === 1'b1) done_seen++;
    if (bus.wrap === 1'b1) wrap_seen++;
  endtask

  task automatic start_sweep(input logic [11:0] s, input logic [11:0] e, input logic [11:0] d,
                             input logic [15:0] w, input logic l, input logic t);
    bus.cfg_start_step = s;
    bus.cfg_stop_step  = e;
    bus.cfg_delta      = d;
    bus.cfg_dwell      = w;
    bus.cfg_loop       = l;
    bus.cfg_tri        = t;
    bus.start          = 1'b1;
    tick(1'b0);
    bus.start          = 1'b0;
    done_seen          = 0;
    wrap_seen          = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    tick(1'b0);
    checks++;
    if (bus.step_out !== 12'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset step_out=%0d busy=%b done=%b wrap=%b expected 0 0 0 0",
               bus.step_out, bus.busy, bus.done, bus.wrap);
    end
  endtask

  task automatic test_up_sweep();
    logic [11:0] vals [4];
    vals = '{12'd100, 12'd110, 12'd120, 12'd130};
    start_sweep(12'd100, 12'd130, 12'd10, 16'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (bus.step_out !== vals[i] || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL up_step[%0d.%0d] step_out=%0d busy=%b expected %0d busy=1",
                   i, p, bus.step_out, bus.busy, vals[i]);
        end
        tick(1'b1);
        if (i == 3 && p == 1) begin
          checks++;
          if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL up_end done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy);
          end
        end
        tick(1'b0);
      end
    end
    checks++;
    if (done_seen != 1 || bus.step_out !== 12'd130 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL up_after done_pulses=%0d step_out=%0d done=%b expected 1 130 0",
               done_seen, bus.step_out, bus.done);
    end
  endtask

  task automatic test_down_clamp();
    logic [11:0] vals [4];
    vals = '{12'd50, 12'd38, 12'd26, 12'd20};
    start_sweep(12'd50, 12'd20, 12'd12, 16'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.step_out !== vals[i] || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL down_step[%0d] step_out=%0d busy=%b expected %0d busy=1",
                 i, bus.step_out, bus.busy, vals[i]);
      end
      tick(1'b1);
    end
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (done_seen != 1 || bus.busy !== 1'b0 || bus.step_out !== 12'd20) begin
      failures++;
      $display("FAIL down_end done_pulses=%0d busy=%b step_out=%0d expected 1 0 20",
               done_seen, bus.busy, bus.step_out);
    end
  endtask

  task automatic test_loop();
    logic [11:0] vals [6];
    vals = '{12'd0, 12'd4, 12'd8, 12'd0, 12'd4, 12'd8};
    start_sweep(12'd0, 12'd8, 12'd4, 16'd1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.step_out !== vals[i] || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL loop_step[%0d] step_out=%0d busy=%b expected %0d busy=1",
                 i, bus.step_out, bus.busy, vals[i]);
      end
      tick(1'b1);
    end
    checks++;
    if (wrap_seen != 2 || done_seen != 0 || bus.step_out !== 12'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL loop_wrap wrap_pulses=%0d done_pulses=%0d step_out=%0d busy=%b expected 2 0 0 1",
               wrap_seen, done_seen, bus.step_out, bus.busy);
    end
    bus.abort = 1'b1;
    tick(1'b0);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.step_out !== 12'd0) begin
      failures++;
      $display("FAIL loop_abort busy=%b step_out=%0d expected 0 0", bus.busy, bus.step_out);
    end
  endtask

  task automatic test_zero_config();
    logic [11:0] vals [3];
    vals = '{12'd5, 12'd6, 12'd7};
    start_sweep(12'd5, 12'd7, 12'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.step_out !== vals[i]) begin
        failures++;
        $display("FAIL zero_step[%0d] step_out=%0d expected %0d", i, bus.step_out, vals[i]);
      end
      tick(1'b1);
    end
    checks++;
    if (done_seen != 1 || bus.busy !== 1'b0 || bus.step_out !== 12'd7) begin
      failures++;
      $display("FAIL zero_end done_pulses=%0d busy=%b step_out=%0d expected 1 0 7",
               done_seen, bus.busy, bus.step_out);
    end
  endtask

  task automatic test_boundaries();
    // start == stop: one dwell period (2 pulses) on the value, then done
    start_sweep(12'd9, 12'd9, 12'd3, 16'd2, 1'b0, 1'b0);
    tick(1'b1);
    checks++;
    if (bus.step_out !== 12'd9 || bus.busy !== 1'b1 || done_seen != 0) begin
      failures++;
      $display("FAIL equal_hold step_out=%0d busy=%b done_pulses=%0d expected 9 1 0",
               bus.step_out, bus.busy, done_seen);
    end
    tick(1'b1);
    checks++;
    if (bus.step_out !== 12'd9 || bus.busy !== 1'b0 || done_seen != 1) begin
      failures++;
      $display("FAIL equal_end step_out=%0d busy=%b done_pulses=%0d expected 9 0 1",
               bus.step_out, bus.busy, done_seen);
    end
    // top of range: 4090 + 10 would pass 4095, clamp instead of wrapping
    start_sweep(12'd4090, 12'd4095, 12'd10, 16'd1, 1'b0, 1'b0);
    tick(1'b1);
    checks++;
    if (bus.step_out !== 12'd4095 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL top_clamp step_out=%0d busy=%b expected 4095 1", bus.step_out, bus.busy);
    end
    tick(1'b1);
    // bottom of range: 5 - 10 would go below 0, clamp at 0
    start_sweep(12'd5, 12'd0, 12'd10, 16'd1, 1'b0, 1'b0);
    tick(1'b1);
    checks++;
    if (bus.step_out !== 12'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL bottom_clamp step_out=%0d busy=%b expected 0 1", bus.step_out, bus.busy);
    end
    tick(1'b1);
    checks++;
    if (bus.busy !== 1'b0 || done_seen != 1) begin
      failures++;
      $display("FAIL bottom_end busy=%b done_pulses=%0d expected 0 1", bus.busy, done_seen);
    end
  endtask

  task automatic test_abort_start();
    start_sweep(12'd100, 12'd130, 12'd10, 16'd1, 1'b0, 1'b0);
    tick(1'b1);
    // new start with different config while busy must be ignored
    bus.cfg_start_step = 12'd7;
    bus.cfg_stop_step  = 12'd9;
    bus.cfg_delta      = 12'd1;
    bus.start          = 1'b1;
    tick(1'b0);
    bus.start          = 1'b0;
    checks++;
    if (bus.step_out !== 12'd110 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start step_out=%0d busy=%b expected 110 1", bus.step_out, bus.busy);
    end
    tick(1'b1);
    checks++;
    if (bus.step_out !== 12'd120) begin
      failures++;
      $display("FAIL shadow_cfg step_out=%0d expected 120", bus.step_out);
    end
    // abort coincides with a qualifying enable_pulse: abort wins
    bus.abort = 1'b1;
    tick(1'b1);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.step_out !== 12'd120 || bus.done !== 1'b0 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL abort step_out=%0d busy=%b done=%b wrap=%b expected 120 0 0 0",
               bus.step_out, bus.busy, bus.done, bus.wrap);
    end
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (bus.step_out !== 12'd120 || bus.busy !== 1'b0 || done_seen != 0) begin
      failures++;
      $display("FAIL abort_hold step_out=%0d busy=%b done_pulses=%0d expected 120 0 0",
               bus.step_out, bus.busy, done_seen);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(1'b0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick(1'b1);
    checks++;
    if (bus.busy !== 1'b0 || bus.step_out !== 12'd120) begin
      failures++;
      $display("FAIL start_abort busy=%b step_out=%0d expected 0 120", bus.busy, bus.step_out);
    end
  endtask

  task automatic test_triangle();
    logic [11:0] vals [5];
    int n;
`ifdef SWEEP_TRIANGLE_EN
    vals = '{12'd10, 12'd20, 12'd30, 12'd20, 12'd10};
    n = 5;
`else
    vals = '{12'd10, 12'd20, 12'd30, 12'd30, 12'd30};
    n = 3;
`endif
    start_sweep(12'd10, 12'd30, 12'd10, 16'd1, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.step_out !== vals[i] || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL tri_step[%0d] step_out=%0d busy=%b expected %0d busy=1",
                 i, bus.step_out, bus.busy, vals[i]);
      end
      tick(1'b1);
    end
    checks++;
    if (done_seen != 1 || bus.busy !== 1'b0 || bus.step_out !== vals[n-1]) begin
      failures++;
      $display("FAIL tri_end done_pulses=%0d busy=%b step_out=%0d expected 1 0 %0d",
               done_seen, bus.busy, bus.step_out, vals[n-1]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    start_sweep(12'd100, 12'd130, 12'd10, 16'd1, 1'b1, 1'b0);
    tick(1'b1);
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    checks++;
    if (bus.step_out !== 12'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid step_out=%0d busy=%b done=%b wrap=%b expected 0 0 0 0",
               bus.step_out, bus.busy, bus.done, bus.wrap);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.enable_pulse   = 1'b0;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.cfg_start_step = '0;
    bus.cfg_stop_step  = '0;
    bus.cfg_delta      = '0;
    bus.cfg_dwell      = '0;
    bus.cfg_loop       = 1'b0;
    bus.cfg_tri        = 1'b0;
    test_reset();
    test_up_sweep();
    test_down_clamp();
    test_loop();
    test_zero_config();
    test_boundaries();
    test_abort_start();
    test_triangle();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
